// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
//   arb_state_t : arbiter FSM state (idle / packet granted)
//   id_width()  : requester index width, never narrower than one bit
package uart_arb_pkg;

   typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

   function automatic int unsigned id_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: returns the first set request bit scanning
// ptr_i, ptr_i+1, ... with wrap at N.
//   req_i   : request vector
//   ptr_i   : highest-priority index this cycle (must be < N)
//   found_o : any request set
//   idx_o   : winning index (0 when nothing is set)
module rr_pick #(
   parameter int unsigned N   = 4,
   parameter int unsigned IDW = 2
) (
   input  logic [N-1:0]   req_i,
   input  logic [IDW-1:0] ptr_i,
   output logic           found_o,
   output logic [IDW-1:0] idx_o
);

   logic [IDW:0] cand;

   assign found_o = |req_i;

   // Walk offsets from farthest to nearest so the offset closest to ptr_i wins last.
   always_comb begin
      idx_o = '0;
      cand  = '0;
      for (int k = int'(N) - 1; k >= 0; k--) begin
         cand = {1'b0, ptr_i} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(N)) begin
            cand = cand - (IDW+1)'(N);
         end
         if (req_i[cand[IDW-1:0]]) begin
            idx_o = cand[IDW-1:0];
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter sharing one uart_tx byte port among
// NUM_REQ requesters. The owner keeps the UART until a byte tagged last is
// accepted. Optional owner-idle timeout is compiled in with the macro
// UART_ARB_TIMEOUT_EN (default build: no timeout, timeout_evt tied 0).
// Ports:
//   clk, rst       : clock, synchronous active-low reset
//   req_valid/data/last, req_ready : per-requester byte handshake
//   tx_data_valid, tx_data, tx_ready : byte port towards uart_tx
//   grant_valid, grant_id : current owner (registered)
//   timeout_evt    : one-cycle pulse on forced release
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter  int unsigned NUM_REQ        = 4,
   parameter  int unsigned DATA_W         = 8,
   parameter  int unsigned TIMEOUT_CYCLES = 1024,
   localparam int unsigned IDW            = id_width(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic                      tx_data_valid,
   output logic [DATA_W-1:0]         tx_data,
   input  logic                      tx_ready,
   output logic                      grant_valid,
   output logic [IDW-1:0]            grant_id,
   output logic                      timeout_evt
);

   arb_state_t     state_q;
   logic [IDW-1:0] rr_ptr_q;
   logic [IDW-1:0] grant_id_q;
   logic           grant_valid_q;

   logic           pick_found;
   logic [IDW-1:0] pick_idx;
   logic           owner_on;
   logic           owner_valid;
   logic           accept;
   logic           last_acc;
   logic [IDW-1:0] ptr_adv;

   rr_pick #(
      .N   (NUM_REQ),
      .IDW (IDW)
   ) u_rr_pick (
      .req_i   (req_valid),
      .ptr_i   (rr_ptr_q),
      .found_o (pick_found),
      .idx_o   (pick_idx)
   );

   // Byte path is only open in GRANT and never while reset is asserted.
   assign owner_on      = rst && (state_q == ARB_GRANT);
   assign owner_valid   = req_valid[grant_id_q];
   assign tx_data_valid = owner_on && owner_valid;
   assign tx_data       = req_data[grant_id_q*DATA_W +: DATA_W];
   assign accept        = tx_data_valid && tx_ready;
   assign last_acc      = accept && req_last[grant_id_q];
   assign ptr_adv       = (grant_id_q == IDW'(NUM_REQ - 1)) ? '0 : grant_id_q + IDW'(1);

   always_comb begin
      req_ready = '0;
      if (owner_on) begin
         req_ready[grant_id_q] = tx_ready;
      end
   end

   assign grant_valid = grant_valid_q;
   assign grant_id    = grant_id_q;

`ifdef UART_ARB_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

   logic [CntW-1:0] idle_cnt_q;
   logic            timeout_evt_q;
   logic            stall_expire;

   assign stall_expire = owner_on && !owner_valid &&
                         (idle_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
   assign timeout_evt  = timeout_evt_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
   assign timeout_evt        = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= ARB_IDLE;
         rr_ptr_q      <= '0;
         grant_id_q    <= '0;
         grant_valid_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
         idle_cnt_q    <= '0;
         timeout_evt_q <= 1'b0;
`endif
      end else begin
`ifdef UART_ARB_TIMEOUT_EN
         timeout_evt_q <= 1'b0;
`endif
         case (state_q)
            ARB_IDLE: begin
               if (pick_found) begin
                  state_q       <= ARB_GRANT;
                  grant_valid_q <= 1'b1;
                  grant_id_q    <= pick_idx;
`ifdef UART_ARB_TIMEOUT_EN
                  idle_cnt_q    <= '0;
`endif
               end
            end
            ARB_GRANT: begin
               if (last_acc) begin
                  state_q       <= ARB_IDLE;
                  grant_valid_q <= 1'b0;
                  rr_ptr_q      <= ptr_adv;
               end
`ifdef UART_ARB_TIMEOUT_EN
               else if (stall_expire) begin
                  state_q       <= ARB_IDLE;
                  grant_valid_q <= 1'b0;
                  rr_ptr_q      <= ptr_adv;
                  timeout_evt_q <= 1'b1;
               end
               // Counts only cycles where the owner has nothing to offer.
               if (accept) begin
                  idle_cnt_q <= '0;
               end else if (!owner_valid) begin
                  idle_cnt_q <= idle_cnt_q + CntW'(1);
               end
`endif
            end
            default: state_q <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus random
// traffic, scored against a transaction-level ownership model.
module tb_uart_tx_arbiter;

   localparam int N   = 4;
   localparam int DW  = 8;
   localparam int TO  = 16;
   localparam int IDW = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_valid;
   logic [N*DW-1:0]   req_data;
   logic [N-1:0]      req_last;
   logic [N-1:0]      req_ready;
   logic              tx_data_valid;
   logic [DW-1:0]     tx_data;
   logic              tx_ready;
   logic              grant_valid;
   logic [IDW-1:0]    grant_id;
   logic              timeout_evt;

   always #5 clk = ~clk;

   uart_tx_arbiter #(
      .NUM_REQ        (N),
      .DATA_W         (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_last      (req_last),
      .req_ready     (req_ready),
      .tx_data_valid (tx_data_valid),
      .tx_data       (tx_data),
      .tx_ready      (tx_ready),
      .grant_valid   (grant_valid),
      .grant_id      (grant_id),
      .timeout_evt   (timeout_evt)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Requester sources: each entry is {last, byte}.
   logic [8:0] pq [N][$];
   bit         cur_v [N];
   bit         hs [N];
   int         hold [N];
   int         hold_after [N];
   int         hold_len [N];
   bit         gaps;
   int         rdy_pct;

   // Reference model: who owns the UART, whose turn is next, idle count.
   int m_owner, m_ptr, m_cnt;
   bit m_tevt;
   bit e_gv, e_txv, e_tevt;
   int e_gid;
   logic [N-1:0] e_rdy;

   logic [IDW+DW-1:0] exp_q [$];
   logic [IDW+DW-1:0] mon_e;

   task automatic model_adv();
      int  idx;
      bit  f;
      m_tevt = 1'b0;
      if (m_owner < 0) begin
         f = 1'b0;
         for (int k = 0; k < N; k++) begin
            idx = (m_ptr + k) % N;
            if (!f && req_valid[idx]) begin
               f       = 1'b1;
               m_owner = idx;
               m_cnt   = 0;
            end
         end
      end else if (req_valid[m_owner] && tx_ready) begin
         if (req_last[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
         end
         m_cnt = 0;
      end
`ifdef UART_ARB_TIMEOUT_EN
      else if (!req_valid[m_owner]) begin
         if (m_cnt == TO - 1) begin
            m_tevt  = 1'b1;
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
         end else begin
            m_cnt++;
         end
      end
`endif
   endtask

   task automatic model_eval();
      e_gv   = (m_owner >= 0);
      e_gid  = m_owner;
      e_txv  = e_gv && req_valid[m_owner];
      e_rdy  = '0;
      if (e_gv && tx_ready) e_rdy[m_owner] = 1'b1;
      e_tevt = m_tevt;
      if (e_txv && tx_ready) exp_q.push_back({IDW'(m_owner), req_data[m_owner*DW +: DW]});
   endtask

   task automatic stim();
      for (int i = 0; i < N; i++) begin
         if (hold[i] > 0) hold[i]--;
         if (cur_v[i] && hs[i]) begin
            void'(pq[i].pop_front());
            cur_v[i] = 1'b0;
            if (hold_after[i] > 0) begin
               hold_after[i]--;
               if (hold_after[i] == 0) hold[i] = hold_len[i];
            end
         end
         if (!cur_v[i] && hold[i] == 0 && pq[i].size() > 0 &&
             (!gaps || $urandom_range(0, 2) == 0)) cur_v[i] = 1'b1;
         req_valid[i] = cur_v[i];
         if (cur_v[i]) begin
            req_data[i*DW +: DW] = pq[i][0][7:0];
            req_last[i]          = pq[i][0][8];
         end else begin
            req_data[i*DW +: DW] = 8'($urandom);
            req_last[i]          = 1'($urandom);
         end
      end
      tx_ready = ($urandom_range(0, 99) < rdy_pct);
   endtask

   task automatic compare();
      chk("grant_valid", int'(grant_valid), int'(e_gv));
      if (e_gv) chk("grant_id", int'(grant_id), e_gid);
      chk("tx_data_valid", int'(tx_data_valid), int'(e_txv));
      chk("req_ready", int'(req_ready), int'(e_rdy));
      chk("timeout_evt", int'(timeout_evt), int'(e_tevt));
      for (int i = 0; i < N; i++) hs[i] = req_valid[i] && req_ready[i];
   endtask

   task automatic cycle();
      @(posedge clk);
      model_adv();
      #1;
      stim();
      model_eval();
      @(negedge clk);
      compare();
   endtask

   function automatic int pending();
      int s = 0;
      for (int i = 0; i < N; i++) s += pq[i].size();
      return s;
   endfunction

   task automatic drain(input string name, input int budget);
      int c = 0;
      while (pending() > 0 && c < budget) begin
         cycle();
         c++;
      end
      chk(name, pending(), 0);
   endtask

   // Monitor: every byte taken by the UART must be the next one predicted.
   always @(negedge clk) begin
      if (rst === 1'b1 && tx_data_valid === 1'b1 && tx_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL tx_byte: got id=%0d data=%02h, required no transfer", grant_id, tx_data);
         end else begin
            mon_e = exp_q.pop_front();
            chk("tx_byte", int'({grant_id, tx_data}), int'(mon_e));
         end
      end
   end

   initial begin
      int r, len;
      rst       = 1'b0;
      req_valid = '1;
      req_last  = '1;
      req_data  = {N{8'h3C}};
      tx_ready  = 1'b1;
      gaps      = 1'b0;
      rdy_pct   = 100;

      // Reset with all requesters asserting.
      @(posedge clk);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("rst_tx_data_valid", int'(tx_data_valid), 0);
         chk("rst_req_ready", int'(req_ready), 0);
         chk("rst_grant_valid", int'(grant_valid), 0);
         chk("rst_timeout_evt", int'(timeout_evt), 0);
      end
      rst       = 1'b1;
      req_valid = '0;
      m_owner   = -1;
      m_ptr     = 0;
      m_cnt     = 0;
      m_tevt    = 1'b0;

      // Single packet from requester 2 with a slow UART.
      rdy_pct = 30;
      pq[2].push_back(9'h0A5);
      pq[2].push_back(9'h05A);
      pq[2].push_back(9'h1DD);
      drain("drain_single", 300);
      repeat (3) cycle();

      // Contention among 0, 1, 3 with one-byte packets.
      rdy_pct = 100;
      for (int k = 0; k < 3; k++) begin
         pq[0].push_back({1'b1, 8'(8'h00 + k)});
         pq[1].push_back({1'b1, 8'(8'h10 + k)});
         pq[3].push_back({1'b1, 8'(8'h30 + k)});
      end
      drain("drain_contention", 300);
      repeat (3) cycle();

      // Lock: owner 1 stalls 50 cycles mid-packet while 0 waits.
      pq[1].push_back(9'h011);
      pq[1].push_back(9'h012);
      pq[1].push_back(9'h113);
      hold_after[1] = 2;
      hold_len[1]   = 50;
      repeat (2) cycle();
      pq[0].push_back(9'h101);
      drain("drain_lock", 400);
      repeat (3) cycle();

      // Wrap: requester 2 finishes, then 0 and 2 compete.
      pq[2].push_back(9'h122);
      drain("drain_wrap_a", 100);
      repeat (2) cycle();
      pq[0].push_back(9'h1A0);
      pq[2].push_back(9'h1A2);
      drain("drain_wrap_b", 100);
      repeat (3) cycle();

      // Owner stall beyond the timeout limit with another requester waiting.
      pq[2].push_back(9'h030);
      pq[2].push_back(9'h031);
      pq[2].push_back(9'h132);
      hold_after[2] = 1;
      hold_len[2]   = 40;
      repeat (2) cycle();
      pq[3].push_back(9'h140);
      drain("drain_timeout", 400);
      repeat (3) cycle();

      // Random traffic with gaps, backpressure and occasional owner stalls.
      gaps = 1'b1;
      for (int t = 0; t < 900; t++) begin
         if (t % 100 == 0) rdy_pct = $urandom_range(20, 100);
         if ($urandom_range(0, 7) == 0) begin
            r   = $urandom_range(0, N - 1);
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) pq[r].push_back({(b == len - 1), 8'($urandom)});
            if ($urandom_range(0, 4) == 0 && hold_after[r] == 0) begin
               hold_after[r] = 1;
               hold_len[r]   = $urandom_range(5, 25);
            end
         end
         cycle();
      end
      rdy_pct = 100;
      drain("drain_random", 3000);
      repeat (5) cycle();
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
